line_rotation_scrambler: RTL and testbench

- Consumes the 11-bit byte-domain cut position produced by the cut-position interpolation stage.
- Applies it to the active-video byte stream (BT.656 CrYCbY, 1440 bytes/line).
- Ping-pong line buffer: line N is written while line N-1 is read out rotated, i.e. bytes [cut..LINE_LEN-1] then [0..cut-1].
- Output cadence is slaved to input cadence; fixed latency of one line plus one clock.

---
 rtl/line_rotation_scrambler.sv | 120 ++++++++++++
 tb/tb_line_rotation_scrambler.sv | 129 ++++++++++++
 2 files changed

// File: rtl/line_rotation_scrambler.sv
// line_rotation_scrambler: ping-pong line buffer that replays each active-video
// line one line later, rotated so output starts at the captured cut position.
// Optional feature macro: LINE_ROTATION_BYPASS_EN adds a per-line bypass input
// that forces the stored cut to 0.
module line_rotation_scrambler #(
  parameter int DATA_W   = 8,
  parameter int LINE_LEN = 1440,
  parameter int ADDR_W   = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_line_start,
  input  logic [ADDR_W-1:0] cut_position,
`ifdef LINE_ROTATION_BYPASS_EN
  input  logic              bypass,
`endif
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_line_start,
  output logic              overflow
);

  localparam logic [ADDR_W:0] LEN_X = (ADDR_W+1)'(LINE_LEN);

  logic [DATA_W-1:0] mem [0:1][0:LINE_LEN-1];
  logic [ADDR_W-1:0] cut_bank [0:1];

  logic              wr_bank;
  logic              started;
  logic              primed;
  logic [ADDR_W:0]   wr_idx;
  logic [ADDR_W:0]   rd_idx;

  logic              line_ev;
  logic [ADDR_W-1:0] cut_masked;
  logic [ADDR_W-1:0] cut_eff;
  logic              new_bank;
  logic              wr_en;
  logic              wr_bank_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_gate;
  logic              rd_bank;
  logic              rd_en;
  logic [ADDR_W:0]   rd_sum;
  logic [ADDR_W:0]   rd_wrap;
  logic [ADDR_W-1:0] rd_addr;

  // Cut capture, bank selection and rotated read-address generation.
  always_comb begin
    line_ev    = in_valid & in_line_start;
    // Clearing the low two bits keeps CrYCbY groups whole.
    cut_masked = {cut_position[ADDR_W-1:2], 2'b00};
    cut_eff    = ({1'b0, cut_masked} >= LEN_X) ? '0 : cut_masked;
`ifdef LINE_ROTATION_BYPASS_EN
    if (bypass) cut_eff = '0;
`endif
    // The very first line after reset lands in bank 0 without a toggle.
    new_bank    = started ? ~wr_bank : 1'b0;
    wr_en       = line_ev | (in_valid & ~in_line_start & started & (wr_idx != LEN_X));
    wr_bank_sel = line_ev ? new_bank : wr_bank;
    wr_addr     = line_ev ? '0 : wr_idx[ADDR_W-1:0];

    // On a line start the bank just completed is still the current wr_bank.
    rd_gate = in_valid & (primed | (in_line_start & started));
    rd_bank = in_line_start ? wr_bank : ~wr_bank;
    rd_sum  = {1'b0, cut_bank[rd_bank]} + (in_line_start ? '0 : rd_idx);
    rd_wrap = (rd_sum >= LEN_X) ? (rd_sum - LEN_X) : rd_sum;
    rd_addr = rd_wrap[ADDR_W-1:0];
    rd_en   = rd_gate & (in_line_start | (rd_idx != LEN_X));
  end

  // Line buffer write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank_sel][wr_addr] <= in_data;
  end

  // Bank/index bookkeeping, per-bank cut storage, priming and overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_bank  <= 1'b0;
      started  <= 1'b0;
      primed   <= 1'b0;
      wr_idx   <= '0;
      rd_idx   <= '0;
      overflow <= 1'b0;
      cut_bank <= '{default: '0};
    end else begin
      if (line_ev) begin
        wr_bank            <= new_bank;
        started            <= 1'b1;
        primed             <= primed | started;
        wr_idx             <= (ADDR_W+1)'(1);
        cut_bank[new_bank] <= cut_eff;
      end else if (in_valid && started) begin
        if (wr_idx != LEN_X) wr_idx <= wr_idx + 1'b1;
        else overflow <= 1'b1;
      end
      if (rd_gate) begin
        if (in_line_start) rd_idx <= (ADDR_W+1)'(1);
        else if (rd_idx != LEN_X) rd_idx <= rd_idx + 1'b1;
      end
    end
  end

  // Registered read port and qualifiers, one clock behind the input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data       <= '0;
      out_valid      <= 1'b0;
      out_line_start <= 1'b0;
    end else begin
      out_valid      <= rd_gate;
      out_line_start <= rd_gate & in_line_start;
      if (rd_en) out_data <= mem[rd_bank][rd_addr];
    end
  end

endmodule

// File: tb/tb_line_rotation_scrambler.sv
// Directed bench for line_rotation_scrambler: input bytes are index mod 256,
// so every rotated output byte is ((cut + k) mod LINE_LEN) mod 256.
module tb_line_rotation_scrambler;
  localparam int LL = 1440;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_line_start = 1'b0;
  logic [10:0] cut_position = '0;
`ifdef LINE_ROTATION_BYPASS_EN
  logic       bypass = 1'b0;
`endif
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_line_start;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  bit have_exp = 0;
  bit exp_v = 0;
  bit exp_ls = 0;
  int exp_d = 0;

  line_rotation_scrambler dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_line_start  (in_line_start),
    .cut_position   (cut_position),
`ifdef LINE_ROTATION_BYPASS_EN
    .bypass         (bypass),
`endif
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_line_start (out_line_start),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One input cycle: first verify the outputs produced by the previous cycle,
  // then drive this cycle and record what it should produce.
  task automatic cycle(input bit v, input bit ls, input int d, input int cut,
                       input bit ev, input int edata, input bit upd);
    @(negedge clk);
    if (have_exp) begin
      check("out_valid", out_valid, exp_v);
      check("out_line_start", out_line_start, exp_ls);
      check("out_data", out_data, exp_d);
    end
    in_valid      = v;
    in_line_start = ls;
    in_data       = d[7:0];
    cut_position  = cut[10:0];
    exp_v         = v & ev;
    exp_ls        = v & ev & ls;
    if (v && ev && upd) exp_d = edata;
    have_exp      = 1;
  endtask

  // n bytes of index data; ecut is the effective cut of the line being replayed.
  task automatic send_line(input int n, input int cut, input bit ev,
                           input int ecut, input bit gaps);
    for (int j = 0; j < n; j++) begin
      cycle(1, j == 0, j % 256, cut, ev, ((ecut + j) % LL) % 256, j < LL);
      if (gaps) cycle(0, 0, 0, cut, ev, 0, 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_line_start", out_line_start, 0);
    check("rst_overflow", overflow, 0);
    reset_n = 1'b1;

    // Bytes before any line start are ignored.
    for (int j = 0; j < 3; j++) cycle(1, 0, 8'hAA, 0, 0, 0, 0);

    send_line(LL, 0,    0, 0,   0);   // first line: nothing out
    send_line(LL, 0,    1, 0,   0);   // replay line 1 unrotated
    send_line(LL, 400,  1, 0,   0);
    send_line(LL, 403,  1, 400, 0);   // replay cut 400, first byte 0x90
    send_line(LL, 1500, 1, 400, 0);   // 403 treated as 400
    check("overflow_before", overflow, 0);
    send_line(1445, 4,  1, 0,   0);   // 1500 -> pass-through; 5 bytes dropped
    check("overflow_set", overflow, 1);
    send_line(LL, 0,    1, 4,   1);   // gapped input, cut 4 replay
    check("overflow_sticky", overflow, 1);

    // Reset in the middle of a line.
    for (int j = 0; j < 700; j++) cycle(1, j == 0, j % 256, 0, 1, j % 256, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_out_data", out_data, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_line_start", out_line_start, 0);
    check("midrst_overflow", overflow, 0);
    in_valid = 1'b0;
    in_line_start = 1'b0;
    have_exp = 0;
    exp_d = 0;
    @(negedge clk);
    reset_n = 1'b1;

    send_line(LL, 8, 0, 0, 0);        // re-priming: nothing out
    send_line(LL, 0, 1, 8, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("overflow_final", overflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
